// File: rtl/uart_program_loader.sv
// UART (8N1) boot loader: receives a length-prefixed program, writes 16-bit words to instruction memory,
// then releases the CPU reset. Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_program_loader #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned ADDR_WIDTH   = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx,
   output logic                  rom_write,
   output logic [ADDR_WIDTH-1:0] rom_address,
   output logic [15:0]           rom_data,
   output logic                  cpu_reset,
   output logic                  loading,
   output logic                  error
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned HALF  = CLKS_PER_BIT / 2;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   typedef enum logic [2:0] {
      S_LEN_HI  = 3'd0,
      S_LEN_LO  = 3'd1,
      S_DATA_HI = 3'd2,
      S_DATA_LO = 3'd3,
      S_RUN     = 3'd4,
      S_ERROR   = 3'd5
`ifdef LOADER_CHECKSUM_EN
      ,
      S_CHECK   = 3'd6
`endif
   } ld_state_e;

   // ---------------------------------------------------------------- receiver
   logic             rx_meta_q, rx_sync_q;
   rx_state_e        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       byte_q, byte_d;
   logic             byte_valid_q, byte_valid_d;
   logic             frame_err_q, frame_err_d;

   // rx is asynchronous to clk; two flops before first use
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state_q   <= RX_IDLE;
         bit_cnt_q    <= '0;
         bit_idx_q    <= 3'd0;
         shift_q      <= 8'd0;
         byte_q       <= 8'd0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_state_q   <= rx_state_d;
         bit_cnt_q    <= bit_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_comb begin
      rx_state_d   = rx_state_q;
      bit_cnt_d    = bit_cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      byte_d       = byte_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_sync_q) begin
               rx_state_d = RX_START;
               bit_cnt_d  = '0;
            end
         end
         RX_START: begin
            // mid-bit resample rejects glitches shorter than half a bit
            if (bit_cnt_q == CNT_W'(HALF - 1)) begin
               bit_cnt_d = '0;
               if (rx_sync_q) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
                  bit_idx_d  = 3'd0;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               bit_cnt_d = '0;
               shift_d   = {rx_sync_q, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               bit_cnt_d  = '0;
               rx_state_d = RX_IDLE;
               if (rx_sync_q) begin
                  byte_valid_d = 1'b1;
                  byte_d       = shift_q;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- loader FSM
   ld_state_e             state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [7:0]            hi_q, hi_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [15:0]           words_q, words_d;
   logic                  rom_write_q, rom_write_d;
   logic [ADDR_WIDTH-1:0] rom_address_q, rom_address_d;
   logic [15:0]           rom_data_q, rom_data_d;
   logic                  cpu_reset_q, cpu_reset_d;
   logic                  loading_q, loading_d;
   logic                  error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            csum_q, csum_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) csum_q <= 8'd0;
      else       csum_q <= csum_d;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_LEN_HI;
         len_q         <= 16'd0;
         hi_q          <= 8'd0;
         idx_q         <= '0;
         words_q       <= 16'd0;
         rom_write_q   <= 1'b0;
         rom_address_q <= '0;
         rom_data_q    <= 16'd0;
         cpu_reset_q   <= 1'b1;
         loading_q     <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         hi_q          <= hi_d;
         idx_q         <= idx_d;
         words_q       <= words_d;
         rom_write_q   <= rom_write_d;
         rom_address_q <= rom_address_d;
         rom_data_q    <= rom_data_d;
         cpu_reset_q   <= cpu_reset_d;
         loading_q     <= loading_d;
         error_q       <= error_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      hi_d          = hi_q;
      idx_d         = idx_q;
      words_d       = words_q;
      rom_write_d   = 1'b0;
      rom_address_d = rom_address_q;
      rom_data_d    = rom_data_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d        = csum_q;
`endif
      if (frame_err_q) begin
         state_d = S_ERROR;
      end else if (byte_valid_q) begin
         case (state_q)
            // a byte while running starts a fresh load
            S_LEN_HI, S_RUN: begin
               len_d   = {byte_q, len_q[7:0]};
               state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
               len_d   = {len_q[15:8], byte_q};
               idx_d   = '0;
               words_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = 8'd0;
`endif
               if ({len_q[15:8], byte_q} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = S_CHECK;
`else
                  state_d = S_RUN;
`endif
               end else begin
                  state_d = S_DATA_HI;
               end
            end
            S_DATA_HI: begin
               hi_d    = byte_q;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ byte_q;
`endif
               state_d = S_DATA_LO;
            end
            S_DATA_LO: begin
               rom_write_d   = 1'b1;
               rom_data_d    = {hi_q, byte_q};
               rom_address_d = idx_q;
               idx_d         = idx_q + ADDR_WIDTH'(1);
               words_d       = words_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
               csum_d        = csum_q ^ byte_q;
`endif
               if (words_q == len_q - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = S_CHECK;
`else
                  state_d = S_RUN;
`endif
               end else begin
                  state_d = S_DATA_HI;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
               state_d = (byte_q == csum_q) ? S_RUN : S_ERROR;
            end
`endif
            default: ;
         endcase
      end
      // outputs are registered from the next state so they track state_q
      cpu_reset_d = (state_d != S_RUN);
      loading_d   = (state_d == S_LEN_LO) || (state_d == S_DATA_HI) || (state_d == S_DATA_LO)
`ifdef LOADER_CHECKSUM_EN
                    || (state_d == S_CHECK)
`endif
                    ;
      error_d     = error_q || (state_d == S_ERROR);
   end

   assign rom_write   = rom_write_q;
   assign rom_address = rom_address_q;
   assign rom_data    = rom_data_q;
   assign cpu_reset   = cpu_reset_q;
   assign loading     = loading_q;
   assign error       = error_q;

endmodule
